// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM sequencing fetch/decode/execute/memory/writeback
module multicycle_control #(
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [6:0]             opcode,
  input  logic                   zero,
  output logic                   pc_write,
  output logic                   adr_src,
  output logic                   ir_write,
  output logic                   mem_write,
  output logic                   reg_write,
  output logic [1:0]             alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             result_src,
  output logic [1:0]             alu_op,
  output logic                   instr_done,
  output logic                   illegal_op,
  output logic [STATE_WIDTH-1:0] state_o
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
  } state_t;
  typedef struct packed {
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res;
    logic [1:0] alu_op;
    logic       done;
    logic       pc_update;
    logic       branch;
  } ctrl_t;
  function automatic ctrl_t f_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.ir_write = 1'b1; c.src_b = 2'b10; c.res = 2'b10; c.pc_update = 1'b1; end
      DECODE:   begin c.src_a = 2'b01; c.src_b = 2'b01; end
      MEMADR:   begin c.src_a = 2'b10; c.src_b = 2'b01; end
      MEMREAD:  c.adr_src = 1'b1;
      MEMWB:    begin c.res = 2'b01; c.reg_write = 1'b1; c.done = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; c.done = 1'b1; end
      EXECUTER: begin c.src_a = 2'b10; c.alu_op = 2'b10; end
      EXECUTEI: begin c.src_a = 2'b10; c.src_b = 2'b01; c.alu_op = 2'b10; end
      ALUWB:    begin c.reg_write = 1'b1; c.done = 1'b1; end
      BEQ:      begin c.src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; c.done = 1'b1; end
      JAL:      begin c.src_a = 2'b01; c.src_b = 2'b10; c.pc_update = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction
  state_t r_state, w_next;
  ctrl_t  r_ctrl, w_c;
  logic   w_illegal;
  // next-state selection; unsupported opcodes and unused encodings fall back to FETCH
  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:              w_next = DECODE;
      DECODE:             w_next = (opcode == OP_LW || opcode == OP_SW) ? MEMADR :
                                   opcode == OP_R   ? EXECUTER :
                                   opcode == OP_I   ? EXECUTEI :
                                   opcode == OP_BEQ ? BEQ :
                                   opcode == OP_JAL ? JAL : FETCH;
      MEMADR:             w_next = opcode == OP_LW ? MEMREAD : opcode == OP_SW ? MEMWRITE : FETCH;
      MEMREAD:            w_next = MEMWB;
      EXECUTER, EXECUTEI: w_next = ALUWB;
      JAL:                w_next = ALUWB;
      default:            w_next = FETCH;
    endcase
  end
  // state register with Moore outputs precomputed for the state being entered
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_ctrl  <= f_ctrl(FETCH);
    end else begin
      r_state <= w_next;
      r_ctrl  <= f_ctrl(w_next);
    end
  end
  assign w_illegal  = r_state == DECODE && w_next == FETCH;
  assign w_c        = reset ? f_ctrl(FETCH) : r_ctrl;
  assign pc_write   = ~reset & (w_c.pc_update | (w_c.branch & zero));
  assign adr_src    = w_c.adr_src;
  assign ir_write   = ~reset & w_c.ir_write;
  assign mem_write  = ~reset & w_c.mem_write;
  assign reg_write  = ~reset & w_c.reg_write;
  assign alu_src_a  = w_c.src_a;
  assign alu_src_b  = w_c.src_b;
  assign result_src = w_c.res;
  assign alu_op     = w_c.alu_op;
  assign instr_done = ~reset & (w_c.done | w_illegal);
  assign illegal_op = ~reset & w_illegal;
  assign state_o    = STATE_WIDTH'(r_state);
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed per-instruction checks of the multicycle control FSM
module tb_multicycle_control;
  logic       clk = 1'b0, reset = 1'b1, zero = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, instr_done, illegal_op;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [3:0] state_o;
  int n_pass = 0, n_total = 0;

  multicycle_control #(.STATE_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
    .instr_done(instr_done), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    reset = 1'b1;
    opcode = 7'b0110011;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = {pc_write, ir_write, mem_write, reg_write, instr_done, illegal_op,
             alu_src_a, alu_src_b, result_src, alu_op};
      n_total++;
      if (obs !== {6'b0, 2'b00, 2'b10, 2'b10, 2'b00})
        $display("FAIL reset_hold cyc %0d: got %b expected %b", i, obs, {6'b0, 8'b00101000});
      else n_pass++;
    end
    reset = 1'b0;
    #1;
    obs = {4'b0, state_o, ir_write, alu_src_b, pc_write, instr_done, illegal_op, mem_write};
    n_total++;
    if (obs !== {4'b0, 4'd0, 1'b1, 2'b10, 1'b1, 3'b000})
      $display("FAIL reset_first_fetch: got %b expected %b", obs, {8'd0, 1'b1, 2'b10, 1'b1, 3'b000});
    else n_pass++;
  endtask

  task automatic test_lw();
    logic [8:0] exp [5] = '{
      {4'd0, 1'b0, 2'b10, 1'b0, 1'b1},
      {4'd1, 1'b0, 2'b00, 1'b0, 1'b0},
      {4'd2, 1'b0, 2'b00, 1'b0, 1'b0},
      {4'd3, 1'b0, 2'b00, 1'b0, 1'b0},
      {4'd4, 1'b1, 2'b01, 1'b1, 1'b0}};
    logic [8:0] obs;
    opcode = 7'b0000011;
    for (int i = 0; i < 5; i++) begin
      obs = {state_o, reg_write, result_src, instr_done, pc_write};
      n_total++;
      if (obs !== exp[i]) $display("FAIL lw cyc %0d: got %b expected %b", i, obs, exp[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_sw();
    logic [7:0] exp [4] = '{
      {4'd0, 4'b0000}, {4'd1, 4'b0000}, {4'd2, 4'b0000}, {4'd5, 4'b1101}};
    logic [7:0] obs;
    opcode = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      obs = {state_o, mem_write, adr_src, reg_write, instr_done};
      n_total++;
      if (obs !== exp[i]) $display("FAIL sw cyc %0d: got %b expected %b", i, obs, exp[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_beq();
    logic [7:0] exp [3];
    logic [7:0] obs;
    opcode = 7'b1100011;
    for (int z = 1; z >= 0; z--) begin
      zero = z[0];
      #1;
      exp[0] = {4'd0, 1'b1, 2'b00, 1'b0};
      exp[1] = {4'd1, 1'b0, 2'b00, 1'b0};
      exp[2] = {4'd9, z[0], 2'b01, 1'b1};
      for (int i = 0; i < 3; i++) begin
        obs = {state_o, pc_write, alu_op, instr_done};
        n_total++;
        if (obs !== exp[i]) $display("FAIL beq zero=%0d cyc %0d: got %b expected %b", z, i, obs, exp[i]);
        else n_pass++;
        tick();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [6:0] exp [4] = '{
      {4'd0, 3'b100}, {4'd1, 3'b000}, {4'd10, 3'b100}, {4'd8, 3'b011}};
    logic [6:0] obs;
    opcode = 7'b1101111;
    for (int i = 0; i < 4; i++) begin
      obs = {state_o, pc_write, reg_write, instr_done};
      n_total++;
      if (obs !== exp[i]) $display("FAIL jal cyc %0d: got %b expected %b", i, obs, exp[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [6:0] exp [3] = '{
      {4'd0, 3'b001}, {4'd1, 3'b110}, {4'd0, 3'b001}};
    logic [6:0] obs;
    opcode = 7'b0000000;
    for (int i = 0; i < 3; i++) begin
      obs = {state_o, illegal_op, instr_done, pc_write};
      n_total++;
      if (obs !== exp[i]) $display("FAIL illegal cyc %0d: got %b expected %b", i, obs, exp[i]);
      else n_pass++;
      if (i < 2) tick();
    end
  endtask

  task automatic test_reset_abort();
    logic [5:0] obs;
    opcode = 7'b0010011;
    tick();
    tick();
    obs = {state_o, reg_write, 1'b0};
    n_total++;
    if (obs !== {4'd7, 2'b00}) $display("FAIL abort_exec: got %b expected %b", obs, {4'd7, 2'b00});
    else n_pass++;
    reset = 1'b1;
    #1;
    obs = {pc_write, ir_write, mem_write, reg_write, instr_done, illegal_op};
    n_total++;
    if (obs !== 6'b0) $display("FAIL abort_in_reset: got %b expected %b", obs, 6'b0);
    else n_pass++;
    tick();
    reset = 1'b0;
    #1;
    obs = {state_o, reg_write, ir_write};
    n_total++;
    if (obs !== {4'd0, 2'b01}) $display("FAIL abort_refetch: got %b expected %b", obs, {4'd0, 2'b01});
    else n_pass++;
    tick();
    obs = {state_o, reg_write, 1'b0};
    n_total++;
    if (obs !== {4'd1, 2'b00}) $display("FAIL abort_decode: got %b expected %b", obs, {4'd1, 2'b00});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
